// File: rtl/softmax_seq.sv
// Sequential softmax: buffers VEC_LEN Q5.12 scores, exponentiates (max-subtracted, LUT product), then divides per element.
// Last accept to first out_valid is VEC_LEN+Y_W+5 cycles; input stalls (in_ready=0) until the last probability transfers.
module softmax_seq #(
    parameter int VEC_LEN = 8,
    parameter int Y_W     = 16,
    parameter int E_FRAC  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [16:0]    in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] out_data,
    output logic           out_last,
    output logic           busy
);
    localparam int IW = $clog2(VEC_LEN);
    localparam int CW = $clog2(VEC_LEN + 3);
    localparam int DW = $clog2(Y_W + 1);
    localparam int EW = E_FRAC + 1;
    localparam int SW = 17 + $clog2(VEC_LEN);

    typedef enum logic [1:0] {ST_LOAD, ST_EXP, ST_DIV, ST_OUT} state_t;

    // LUT contents are tabulated for 16 fractional bits of e^-x.
    function automatic logic [EW-1:0] lut0(input logic [3:0] i);
        case (i)
            4'd0:    lut0 = EW'(65536);
            4'd1:    lut0 = EW'(24109);
            4'd2:    lut0 = EW'(8869);
            4'd3:    lut0 = EW'(3263);
            4'd4:    lut0 = EW'(1200);
            4'd5:    lut0 = EW'(442);
            4'd6:    lut0 = EW'(162);
            4'd7:    lut0 = EW'(60);
            4'd8:    lut0 = EW'(22);
            4'd9:    lut0 = EW'(8);
            4'd10:   lut0 = EW'(3);
            4'd11:   lut0 = EW'(1);
            default: lut0 = '0;
        endcase
    endfunction

    function automatic logic [EW-1:0] lut1(input logic [3:0] i);
        case (i)
            4'd0:    lut1 = EW'(65536);
            4'd1:    lut1 = EW'(61565);
            4'd2:    lut1 = EW'(57835);
            4'd3:    lut1 = EW'(54331);
            4'd4:    lut1 = EW'(51039);
            4'd5:    lut1 = EW'(47947);
            4'd6:    lut1 = EW'(45042);
            4'd7:    lut1 = EW'(42313);
            4'd8:    lut1 = EW'(39750);
            4'd9:    lut1 = EW'(37341);
            4'd10:   lut1 = EW'(35079);
            4'd11:   lut1 = EW'(32954);
            4'd12:   lut1 = EW'(30957);
            4'd13:   lut1 = EW'(29081);
            4'd14:   lut1 = EW'(27319);
            default: lut1 = EW'(25664);
        endcase
    endfunction

    function automatic logic [EW-1:0] lut2(input logic [3:0] i);
        case (i)
            4'd0:    lut2 = EW'(65536);
            4'd1:    lut2 = EW'(65280);
            4'd2:    lut2 = EW'(65026);
            4'd3:    lut2 = EW'(64772);
            4'd4:    lut2 = EW'(64520);
            4'd5:    lut2 = EW'(64268);
            4'd6:    lut2 = EW'(64018);
            4'd7:    lut2 = EW'(63768);
            4'd8:    lut2 = EW'(63520);
            4'd9:    lut2 = EW'(63272);
            4'd10:   lut2 = EW'(63025);
            4'd11:   lut2 = EW'(62780);
            4'd12:   lut2 = EW'(62535);
            4'd13:   lut2 = EW'(62291);
            4'd14:   lut2 = EW'(62048);
            default: lut2 = EW'(61806);
        endcase
    endfunction

    // e^(-f/4096) stays below half an LSB of its linear term for f<16.
    function automatic logic [EW-1:0] lut3(input logic [3:0] i);
        lut3 = EW'(65536 - 16 * int'(i));
    endfunction

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   dc_q;
    logic [16:0]     max_q;
    logic [SW-1:0]   sum_q;
    logic [SW-1:0]   rem_q;
    logic [Y_W-1:0]  quo_q;
    logic [16:0]     vec_q [VEC_LEN];
    logic [EW-1:0]   p1_q, p2_q, e_q;
    logic [3:0]      f2_q, f3_q, f3b_q;
    logic            in_ready_q, out_valid_q, out_last_q, busy_q;
    logic [Y_W-1:0]  out_data_q;

    logic [IW-1:0]   rd_idx, wr_idx;
    logic [16:0]     x_rd;
    logic [17:0]     m18;
    logic            e_zero;
    logic [2*EW-1:0] prod1, prod2, prod3;
    logic [EW-1:0]   p1_d, p2_d, e_d;
    logic [SW:0]     div_a;
    logic            div_ge;
    logic [SW-1:0]   rem_d;
    logic [Y_W:0]    q_full;
    logic [Y_W-1:0]  q_sat;

    // Exp pipe: issue at cnt, result lands in e_q three cycles later.
    assign rd_idx = (cnt_q < CW'(VEC_LEN)) ? cnt_q[IW-1:0] : '0;
    assign wr_idx = IW'(cnt_q - CW'(3));
    assign x_rd   = vec_q[rd_idx];
    assign m18    = {max_q[16], max_q} - {x_rd[16], x_rd};
    assign e_zero = (m18 >= 18'h10000);
    assign prod1  = (2*EW)'(lut0(m18[15:12])) * (2*EW)'(lut1(m18[11:8]));
    assign p1_d   = e_zero ? '0 : EW'(prod1 >> E_FRAC);
    assign prod2  = (2*EW)'(p1_q) * (2*EW)'(lut2(f2_q));
    assign p2_d   = EW'(prod2 >> E_FRAC);
    assign prod3  = (2*EW)'(p2_q) * (2*EW)'(lut3(f3b_q));
    assign e_d    = EW'(prod3 >> E_FRAC);

    // Restoring divider: first step uses e itself, later steps the doubled remainder.
    assign div_a  = (dc_q == '0) ? (SW+1)'(vec_q[idx_q]) : {rem_q, 1'b0};
    assign div_ge = (div_a >= {1'b0, sum_q});
    assign rem_d  = div_ge ? SW'(div_a - {1'b0, sum_q}) : SW'(div_a);
    assign q_full = {quo_q, div_ge};
    assign q_sat  = q_full[Y_W] ? '1 : q_full[Y_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            dc_q        <= '0;
            max_q       <= 17'h10000;
            sum_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            p1_q  <= p1_d;
            f2_q  <= m18[7:4];
            f3_q  <= m18[3:0];
            p2_q  <= p2_d;
            f3b_q <= f3_q;
            e_q   <= e_d;
            case (state_q)
                ST_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        vec_q[idx_q] <= in_data;
                        if ($signed(in_data) > $signed(max_q)) begin
                            max_q <= in_data;
                        end
                        if (idx_q == IW'(VEC_LEN - 1)) begin
                            idx_q      <= '0;
                            cnt_q      <= '0;
                            state_q    <= ST_EXP;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_EXP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q >= CW'(3)) begin
                        vec_q[wr_idx] <= e_q;
                        sum_q         <= sum_q + SW'(e_q);
                    end
                    if (cnt_q == CW'(VEC_LEN + 2)) begin
                        state_q <= ST_DIV;
                        dc_q    <= '0;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= q_full[Y_W-1:0];
                    dc_q  <= dc_q + 1'b1;
                    if (dc_q == DW'(Y_W)) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= q_sat;
                        out_last_q  <= (idx_q == IW'(VEC_LEN - 1));
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q    <= ST_LOAD;
                            idx_q      <= '0;
                            max_q      <= 17'h10000;
                            sum_q      <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            dc_q    <= '0;
                            state_q <= ST_DIV;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_seq.sv
// Scoreboard bench for softmax_seq: expectations come from a real-valued LUT model at stimulus time.
`timescale 1ns/1ps
module tb_softmax_seq;
    localparam int VEC_LEN = 8;
    localparam int Y_W     = 16;
    localparam int E_FRAC  = 16;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [16:0]    in_data;
    logic [Y_W-1:0] out_data;

    softmax_seq #(.VEC_LEN(VEC_LEN), .Y_W(Y_W), .E_FRAC(E_FRAC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef logic [16:0] vec_t [VEC_LEN];
    typedef logic [Y_W:0] ent_t;

    int   n_vec = 0;
    int   n_bad = 0;
    ent_t exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic longint lut(input int stage, input int i);
        real scale;
        scale = (stage == 0) ? 1.0 : (stage == 1) ? 16.0 : (stage == 2) ? 256.0 : 4096.0;
        if (i == 0) return 65536;
        return longint'($rtoi($exp(-(real'(i) / scale)) * 65536.0 + 0.5));
    endfunction

    function automatic int sx(input logic [16:0] v);
        return int'($signed(v));
    endfunction

    function automatic longint exp_of(input int m);
        longint p;
        if (m >= 65536) return 0;
        p = (lut(0, m >> 12) * lut(1, (m >> 8) & 15)) >> 16;
        p = (p * lut(2, (m >> 4) & 15)) >> 16;
        return (p * lut(3, m & 15)) >> 16;
    endfunction

    task automatic push_expect(input vec_t sc);
        int     mx;
        longint e [VEC_LEN];
        longint sum, q;
        ent_t   ent;
        mx  = -65536;
        sum = 0;
        for (int i = 0; i < VEC_LEN; i++) if (sx(sc[i]) > mx) mx = sx(sc[i]);
        for (int i = 0; i < VEC_LEN; i++) begin
            e[i] = exp_of(mx - sx(sc[i]));
            sum += e[i];
        end
        for (int i = 0; i < VEC_LEN; i++) begin
            q = (e[i] << Y_W) / sum;
            if (q > 65535) q = 65535;
            ent = {i == VEC_LEN - 1, Y_W'(q)};
            exp_q.push_back(ent);
        end
    endtask

    // in_mode: 0 = valid while scores remain, 1 = valid held high throughout, 2 = valid every other cycle
    task automatic run_vec(input string nm, input vec_t sc, input int in_mode,
                           input int stall_at, input int stall_len);
        int   k, outs, cyc, acc_cyc, prev_xfer, stall_done, busy_bad, hold_bad;
        bit   done, first_seen, was_valid;
        ent_t held, cur, want;
        push_expect(sc);
        k = 0; outs = 0; cyc = 0; acc_cyc = 0; prev_xfer = 0;
        stall_done = 0; busy_bad = 0; hold_bad = 0;
        done = 0; first_seen = 0; was_valid = 0; held = '0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            case (in_mode)
                0:       in_valid = (k < VEC_LEN);
                1:       in_valid = 1'b1;
                default: in_valid = (k < VEC_LEN) && (cyc % 2 == 0);
            endcase
            if (k < VEC_LEN) in_data = sc[k];
            else             in_data = 17'h1abcd;
            if (k >= VEC_LEN && cyc > acc_cyc && (in_ready !== 1'b0 || busy !== 1'b1)) busy_bad++;
            if (in_valid && in_ready) begin
                k++;
                if (k == VEC_LEN) acc_cyc = cyc;
            end

            out_ready = 1'b1;
            cur = {out_last, out_data};
            if (out_valid === 1'b1) begin
                if (!first_seen) begin
                    first_seen = 1;
                    chk({nm, ":latency"}, cyc - acc_cyc, VEC_LEN + Y_W + 5);
                end else if (!was_valid) begin
                    chk($sformatf("%s:gap%0d", nm, outs), cyc - prev_xfer, Y_W + 2);
                end
                if (outs == stall_at) begin
                    if (stall_done == 0) held = cur;
                    else if (cur !== held) hold_bad++;
                    if (stall_done < stall_len) begin
                        out_ready = 1'b0;
                        stall_done++;
                    end
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk({nm, ":extra_out"}, exp_q.size(), 1);
                        done = 1;
                    end else begin
                        want = exp_q.pop_front();
                        chk($sformatf("%s:data%0d", nm, outs), out_data, want[Y_W-1:0]);
                        chk($sformatf("%s:last%0d", nm, outs), out_last, want[Y_W]);
                        done = want[Y_W];
                    end
                    outs++;
                    prev_xfer = cyc;
                end
            end
            was_valid = (out_valid === 1'b1);
        end
        chk({nm, ":finished"}, done, 1);
        chk({nm, ":accepts"}, k, VEC_LEN);
        chk({nm, ":busy_window"}, busy_bad, 0);
        if (stall_len > 0) chk({nm, ":stall_hold"}, hold_bad, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({nm, ":idle_after"}, {in_ready, busy, out_valid}, 3'b100);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {in_ready, out_valid, out_last, busy, out_data}, {1'b1, 3'b000, 16'h0000});

        v = '{default: 17'h00000};
        run_vec("uniform", v, 0, -1, 0);

        v = '{17'h00000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000};
        run_vec("saturate", v, 0, -1, 0);

        v = '{17'h01000, 17'h00000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000};
        run_vec("two_hot", v, 0, -1, 0);

        v = '{default: 17'h00000};
        run_vec("stall", v, 0, 2, 5);

        // Abort a vector partway through its exp phase.
        for (int i = 0; i < VEC_LEN; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 17'h00000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_exp_reset", {in_ready, out_valid, busy}, 3'b100);
        v = '{17'h01000, 17'h00000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h10000};
        run_vec("after_reset", v, 0, -1, 0);

        v = '{17'h00000, 17'h1f000, 17'h1e000, 17'h1d000, 17'h1c000, 17'h1b000, 17'h1a000, 17'h19000};
        run_vec("held_valid", v, 1, -1, 0);

        v = '{17'h00abc, 17'h1f123, 17'h01234, 17'h1ff00, 17'h00001, 17'h1e800, 17'h00777, 17'h1fabc};
        run_vec("fractional", v, 2, 4, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
